alu_issue_stage: RTL and testbench

Upstream neighbour of the 16-bit `ALU`: holds an 8-entry × 16-bit register file, accepts one register-register instruction per cycle over a valid/ready handshake, and registers operands and opcode into the ALU's `input_a`/`input_b`/`op`. It writes the ALU's combinational `out` back to the destination register and reports each retired result. The pair of this block and the ALU forms the execute/writeback slice of the datapath.

---
 rtl/alu_pkg.sv | 11 +
 rtl/reg_file_2r1w.sv | 37 +++
 rtl/alu_issue_stage.sv | 91 +++++++++
 tb/tb_alu_issue_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and opcode constants for the ALU execute/writeback slice.
package alu_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_N      = 8;
  localparam int REG_ADDR_W = 3;
  localparam int OP_W       = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_OR  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
endpackage

// File: rtl/reg_file_2r1w.sv
// 8 x 16 register file: two combinational read ports, r0 hard-wired to zero.
// The write port carries the writeback and the already-arbitrated host write.
module reg_file_2r1w
  import alu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  host_en,
  input  logic [REG_ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0]     host_data
);
  logic [DATA_W-1:0] rf [REG_N];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < REG_N; i++) begin
        if (wb_en && wb_addr == REG_ADDR_W'(i))
          rf[i] <= wb_data;
        else if (host_en && host_addr == REG_ADDR_W'(i))
          rf[i] <= host_data;
      end
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : rf[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : rf[rd_addr_b];
endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage feeding the external 16-bit ALU: registered operands,
// bypassed reads, and a registered retired-result report.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic                  hold,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     input_a,
  output logic [DATA_W-1:0]     input_b,
  output logic [OP_W-1:0]       op,
  input  logic [DATA_W-1:0]     out,
  output logic                  res_valid,
  output logic [REG_ADDR_W-1:0] res_rd,
  output logic [DATA_W-1:0]     res_data
);
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb;
  logic                  accept;
  logic                  host_en;
  logic [DATA_W-1:0]     rf_a, rf_b;
  logic [DATA_W-1:0]     opnd_a, opnd_b;

  assign in_ready = !hold;
  assign accept   = in_valid && !hold;
  assign wb       = ex_valid && !hold;
  // Writeback owns the register when both target the same one.
  assign host_en  = wr_en && !(wb && ex_rd == wr_addr);

  reg_file_2r1w u_rf (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr_a (in_rs),
    .rd_data_a (rf_a),
    .rd_addr_b (in_rt),
    .rd_data_b (rf_b),
    .wb_en     (wb),
    .wb_addr   (ex_rd),
    .wb_data   (out),
    .host_en   (host_en),
    .host_addr (wr_addr),
    .host_data (wr_data)
  );

  always_comb begin
    opnd_a = rf_a;
    if (wb && ex_rd == in_rs && in_rs != '0)          opnd_a = out;
    else if (wr_en && wr_addr == in_rs && in_rs != '0) opnd_a = wr_data;
    opnd_b = rf_b;
    if (wb && ex_rd == in_rt && in_rt != '0)          opnd_b = out;
    else if (wr_en && wr_addr == in_rt && in_rt != '0) opnd_b = wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      input_a   <= '0;
      input_b   <= '0;
      op        <= '0;
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
    end else begin
      if (accept) begin
        ex_valid <= 1'b1;
        ex_rd    <= in_rd;
        input_a  <= opnd_a;
        input_b  <= opnd_b;
        op       <= in_op;
      end else if (!hold) begin
        ex_valid <= 1'b0;
      end
      res_valid <= wb;
      if (wb) begin
        res_rd   <= ex_rd;
        res_data <= out;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench with a behavioural ALU and a scoreboard of retired results.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, hold, wr_en, res_valid;
  logic [3:0]  in_op, op;
  logic [2:0]  in_rd, in_rs, in_rt, wr_addr, res_rd;
  logic [15:0] wr_data, input_a, input_b, out, res_data;

  int n_pass = 0;
  int n_total = 0;
  logic [18:0] exp_q[$];

  always #5 clock = ~clock;

  alu_issue_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .input_a(input_a), .input_b(input_b), .op(op), .out(out),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data)
  );

  always_comb begin
    case (op)
      OP_ADD:  out = input_a + input_b;
      OP_OR:   out = input_a | input_b;
      OP_AND:  out = input_a & input_b;
      default: out = input_a ^ input_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic issue(input logic v, input logic [3:0] o, input logic [2:0] d, s, t);
    in_valid = v; in_op = o; in_rd = d; in_rs = s; in_rt = t;
  endtask

  task automatic host(input logic e, input logic [2:0] a, input logic [15:0] dt);
    wr_en = e; wr_addr = a; wr_data = dt;
  endtask

  task automatic expect_res(input logic [2:0] rd, input logic [15:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", {13'd0, res_rd, res_data}, 32'hFFFF_FFFF);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("res_rd", {29'd0, res_rd}, {29'd0, e[18:16]});
        chk("res_data", {16'd0, res_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    reset_n = 1'b0; hold = 1'b0;
    issue(0, 0, 0, 0, 0);
    host(0, 0, 0);
    #12;
    chk("rst_input_a", {16'd0, input_a}, 0);
    chk("rst_input_b", {16'd0, input_b}, 0);
    chk("rst_op", {28'd0, op}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_rd", {29'd0, res_rd}, 0);
    chk("rst_res_data", {16'd0, res_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clock);
    reset_n = 1'b1;
    cyc;

    // Load and add
    host(1, 1, 16'd5); cyc;
    host(1, 2, 16'd7); cyc;
    host(0, 0, 0);
    issue(1, OP_ADD, 3, 1, 2); cyc;
    chk("add_a", {16'd0, input_a}, 5);
    chk("add_b", {16'd0, input_b}, 7);
    chk("add_op", {28'd0, op}, 0);
    expect_res(3, 16'd12);
    // Dependent chain through bypass
    issue(1, OP_ADD, 4, 3, 3); cyc;
    chk("dep_a", {16'd0, input_a}, 12);
    chk("dep_b", {16'd0, input_b}, 12);
    expect_res(4, 16'd24);
    issue(0, 0, 0, 0, 0); cyc;
    // File read after writeback
    issue(1, OP_AND, 7, 3, 4); cyc;
    chk("file_a", {16'd0, input_a}, 12);
    chk("file_b", {16'd0, input_b}, 24);
    expect_res(7, 16'd8);
    issue(0, 0, 0, 0, 0); cyc;

    // Hold with add r5,r1,r1 in EX
    issue(1, OP_ADD, 5, 1, 1); cyc;
    chk("hold_issue_a", {16'd0, input_a}, 5);
    expect_res(5, 16'd10);
    issue(1, OP_OR, 1, 2, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      cyc;
      chk("hold_res_valid", {31'd0, res_valid}, 0);
      chk("hold_a", {16'd0, input_a}, 5);
      chk("hold_b", {16'd0, input_b}, 5);
    end
    issue(0, 0, 0, 0, 0);
    hold = 1'b0;
    cyc;
    chk("release_res_valid", {31'd0, res_valid}, 1);
    cyc;
    chk("release_one_shot", {31'd0, res_valid}, 0);

    // r0 destination and sources
    issue(1, OP_OR, 0, 1, 2); cyc;
    chk("r0_a", {16'd0, input_a}, 5);
    chk("r0_b", {16'd0, input_b}, 7);
    chk("r0_op", {28'd0, op}, 1);
    expect_res(0, 16'd7);
    issue(1, OP_ADD, 1, 0, 0); cyc;
    chk("r0_read_a", {16'd0, input_a}, 0);
    chk("r0_read_b", {16'd0, input_b}, 0);
    expect_res(1, 16'd0);
    issue(0, 0, 0, 0, 0); cyc;

    // Write collision on r2
    host(1, 5, 16'h00F0); cyc;
    host(1, 6, 16'h000F); cyc;
    host(0, 0, 0);
    issue(1, OP_OR, 2, 5, 6); cyc;
    expect_res(2, 16'h00FF);
    issue(0, 0, 0, 0, 0);
    host(1, 2, 16'hAAAA); cyc;
    host(0, 0, 0);
    issue(1, OP_AND, 3, 2, 2); cyc;
    chk("collide_r2", {16'd0, input_a}, 16'h00FF);
    expect_res(3, 16'h00FF);
    // Writeback to r4 alongside host write to r6
    issue(1, OP_OR, 4, 5, 5); cyc;
    expect_res(4, 16'h00F0);
    issue(0, 0, 0, 0, 0);
    host(1, 6, 16'h1234); cyc;
    host(0, 0, 0);
    issue(1, OP_ADD, 7, 6, 4); cyc;
    chk("side_r6", {16'd0, input_a}, 16'h1234);
    chk("side_r4", {16'd0, input_b}, 16'h00F0);
    expect_res(7, 16'h1324);
    // Host-write bypass into the issuing instruction
    issue(1, OP_ADD, 1, 6, 6);
    host(1, 6, 16'h0002); cyc;
    chk("hbyp_a", {16'd0, input_a}, 2);
    chk("hbyp_b", {16'd0, input_b}, 2);
    expect_res(1, 16'd4);
    issue(0, 0, 0, 0, 0);
    host(0, 0, 0); cyc;
    cyc;

    // Async reset between accept and writeback
    issue(1, OP_ADD, 5, 6, 6); cyc;
    chk("pre_rst_a", {16'd0, input_a}, 2);
    issue(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a", {16'd0, input_a}, 0);
    chk("mid_rst_b", {16'd0, input_b}, 0);
    chk("mid_rst_op", {28'd0, op}, 0);
    chk("mid_rst_res_data", {16'd0, res_data}, 0);
    cyc;
    chk("mid_rst_res_valid", {31'd0, res_valid}, 0);
    reset_n = 1'b1;
    cyc;
    chk("post_rst_res_valid", {31'd0, res_valid}, 0);
    issue(1, 4'hF, 2, 6, 7); cyc;
    chk("post_rst_r6", {16'd0, input_a}, 0);
    chk("post_rst_r7", {16'd0, input_b}, 0);
    chk("opaque_op", {28'd0, op}, 15);
    expect_res(2, 16'd0);
    issue(0, 0, 0, 0, 0); cyc;
    cyc;
    cyc;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
